// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic issue controller.
// Widths, datapath opcodes and FSM state encoding.
package arith_pkg;

    localparam int W    = 16;
    localparam int NREG = 4;
    localparam int AW   = 2;
    localparam int REPW = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADDC  = 3'b001;
    localparam logic [2:0] OP_SUBN  = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_PASS  = 3'b100;
    localparam logic [2:0] OP_INC   = 3'b101;
    localparam logic [2:0] OP_DEC   = 3'b110;
    localparam logic [2:0] OP_PASS2 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operand B source select resolved at accept time.
    function automatic logic [W-1:0] pick_b(
        input logic         imm_sel,
        input logic [W-1:0] imm,
        input logic [W-1:0] rf_b
    );
        return imm_sel ? imm : rf_b;
    endfunction

endpackage

// File: rtl/arith_issue_ctrl_if.sv
// Command and result handshake bundle.
// master = command producer / result consumer, slave = controller.
interface arith_issue_ctrl_if;
    import arith_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [AW-1:0]   cmd_ra;
    logic [AW-1:0]   cmd_rb;
    logic            cmd_imm_sel;
    logic [W-1:0]    cmd_imm;
    logic [AW-1:0]   cmd_rd;
    logic [REPW-1:0] cmd_rep;

    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;
    logic            res_co;
    logic            res_co_any;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb,
        output cmd_imm_sel, cmd_imm, cmd_rd, cmd_rep,
        input  cmd_ready,
        input  res_valid, res_data, res_co, res_co_any,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb,
        input  cmd_imm_sel, cmd_imm, cmd_rd, cmd_rep,
        output cmd_ready,
        output res_valid, res_data, res_co, res_co_any,
        input  res_ready
    );

endinterface

// File: rtl/arith_regfile.sv
// NREG x W register file: three async read ports,
// one synchronous write port, cleared on reset.
module arith_regfile
    import arith_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_i,
    input  logic [AW-1:0] rb_i,
    input  logic [AW-1:0] dbg_i,
    output logic [W-1:0]  a_o,
    output logic [W-1:0]  b_o,
    output logic [W-1:0]  dbg_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i
);

    logic [W-1:0] regs_q [NREG];

    assign a_o   = regs_q[ra_i];
    assign b_o   = regs_q[rb_i];
    assign dbg_o = regs_q[dbg_i];

    // Storage: clear on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/arith_issue_ctrl.sv
// Issue/iterate/writeback controller in front of the
// combinational 16-bit arithmetic datapath.
module arith_issue_ctrl
    import arith_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W-1:0]       wr_data,
    input  logic [AW-1:0]      rf_raddr,
    output logic [W-1:0]       rf_rdata,
    arith_issue_ctrl_if.slave  bus,
    output logic [W-1:0]       dp_a,
    output logic [W-1:0]       dp_b,
    output logic [2:0]         dp_opcode,
    input  logic [W-1:0]       dp_y,
    input  logic               dp_co
);

    state_t          state_q;
    logic [W-1:0]    op_a_q;
    logic [W-1:0]    op_b_q;
    logic [2:0]      op_q;
    logic [AW-1:0]   rd_q;
    logic [REPW-1:0] cnt_q;
    logic            first_q;
    logic            co_any_q;
    logic [W-1:0]    acc_q;
    logic            res_valid_q;
    logic [W-1:0]    res_data_q;
    logic            res_co_q;
    logic            res_co_any_q;

    logic [W-1:0]    rf_a;
    logic [W-1:0]    rf_b;
    logic            in_idle;
    logic            in_exec;
    logic            last_d;
    logic            host_we;
    logic            rf_we_d;
    logic [AW-1:0]   rf_waddr_d;
    logic [W-1:0]    rf_wdata_d;

    assign in_idle = (state_q == ST_IDLE);
    assign in_exec = (state_q == ST_EXEC);
    assign last_d  = in_exec && (cnt_q == '0);
    assign host_we = in_idle && wr_en;

    assign bus.cmd_ready  = in_idle;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_co     = res_co_q;
    assign bus.res_co_any = res_co_any_q;

    // Datapath drive is forced to zero outside EXEC.
    always_comb begin
        dp_a      = '0;
        dp_b      = '0;
        dp_opcode = '0;
        if (in_exec) begin
            dp_a      = first_q ? op_a_q : acc_q;
            dp_b      = op_b_q;
            dp_opcode = op_q;
        end
    end

    // Write port mux: final writeback wins; host only in IDLE.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        unique case (1'b1)
            last_d: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rd_q;
                rf_wdata_d = dp_y;
            end
            host_we: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = wr_addr;
                rf_wdata_d = wr_data;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    arith_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_i    (bus.cmd_ra),
        .rb_i    (bus.cmd_rb),
        .dbg_i   (rf_raddr),
        .a_o     (rf_a),
        .b_o     (rf_b),
        .dbg_o   (rf_rdata),
        .we_i    (rf_we_d),
        .waddr_i (rf_waddr_d),
        .wdata_i (rf_wdata_d)
    );

    // Control FSM with operand latches and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            co_any_q     <= 1'b0;
            acc_q        <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_co_q     <= 1'b0;
            res_co_any_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_a_q   <= rf_a;
                        op_b_q   <= pick_b(bus.cmd_imm_sel,
                                           bus.cmd_imm, rf_b);
                        op_q     <= bus.cmd_op;
                        rd_q     <= bus.cmd_rd;
                        cnt_q    <= bus.cmd_rep;
                        first_q  <= 1'b1;
                        co_any_q <= 1'b0;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_q    <= dp_y;
                    first_q  <= 1'b0;
                    co_any_q <= co_any_q | dp_co;
                    if (cnt_q == '0) begin
                        res_data_q   <= dp_y;
                        res_co_q     <= dp_co;
                        res_co_any_q <= co_any_q | dp_co;
                        res_valid_q  <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_issue_ctrl.sv
// Bench for arith_issue_ctrl: datapath model, transaction-level
// reference checked every cycle, plus directed literal checks.
module tb_arith_issue_ctrl;
    import arith_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [AW-1:0] rf_raddr = '0;
    logic [W-1:0]  rf_rdata;
    logic [W-1:0]  dp_a;
    logic [W-1:0]  dp_b;
    logic [2:0]    dp_opcode;
    logic [W-1:0]  dp_y;
    logic          dp_co;

    int n_tests = 0;
    int n_fail  = 0;

    arith_issue_ctrl_if bus ();

    arith_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .bus       (bus),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_opcode (dp_opcode),
        .dp_y      (dp_y),
        .dp_co     (dp_co)
    );

    always #5 clk = ~clk;

    // Datapath: {co, y} from 17-bit unsigned sums.
    function automatic logic [16:0] dp_eval(
        input logic [2:0]  op,
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [31:0] s;
        logic [15:0] na;
        logic [15:0] nb;
        na = ~a;
        nb = ~b;
        case (op)
            OP_ADD:  s = 32'(a) + 32'(b);
            OP_ADDC: s = 32'(a) + 32'(b) + 1;
            OP_SUBN: s = 32'(b) + 32'(na) + 1;
            OP_SUB:  s = 32'(a) + 32'(nb) + 1;
            OP_PASS: s = 32'(a);
            OP_INC:  s = 32'(a) + 1;
            OP_DEC:  s = 32'(a) + 32'hFFFF;
            default: s = 32'(b);
        endcase
        return s[16:0];
    endfunction

    always_comb {dp_co, dp_y} = dp_eval(dp_opcode, dp_a, dp_b);

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h",
                     nm, act, exp);
        end
    endtask

    // Reference model: whole command evaluated at accept.
    bit          m_idle;
    bit          m_exec;
    bit          m_valid;
    logic [15:0] m_data;
    bit          m_co;
    bit          m_coany;
    logic [15:0] m_rf [4];
    logic [15:0] m_as [17];
    logic [15:0] m_b;
    logic [2:0]  m_op;
    logic [1:0]  m_rd;
    int          m_iter;
    int          m_n;
    logic [15:0] m_y;
    bit          m_yco;
    bit          m_yany;

    task automatic model_reset();
        m_idle  = 1;
        m_exec  = 0;
        m_valid = 0;
        m_data  = 0;
        m_co    = 0;
        m_coany = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
    endtask

    task automatic model_step();
        logic [15:0] a;
        logic [16:0] r;
        if (m_idle) begin
            if (bus.cmd_valid) begin
                a    = m_rf[bus.cmd_ra];
                m_b  = bus.cmd_imm_sel ? bus.cmd_imm
                                       : m_rf[bus.cmd_rb];
                m_op = bus.cmd_op;
                m_rd = bus.cmd_rd;
                m_n  = int'(bus.cmd_rep) + 1;
                m_yany = 0;
                for (int i = 0; i < m_n; i++) begin
                    m_as[i] = a;
                    r = dp_eval(m_op, a, m_b);
                    a = r[15:0];
                    m_yco = r[16];
                    m_yany = m_yany | r[16];
                end
                m_y    = a;
                m_iter = 0;
                m_exec = 1;
                m_idle = 0;
            end
            if (wr_en) m_rf[wr_addr] = wr_data;
        end else if (m_exec) begin
            m_iter++;
            if (m_iter == m_n) begin
                m_exec  = 0;
                m_valid = 1;
                m_data  = m_y;
                m_co    = m_yco;
                m_coany = m_yany;
                m_rf[m_rd] = m_y;
            end
        end else if (bus.res_ready) begin
            m_valid = 0;
            m_idle  = 1;
        end
    endtask

    initial model_reset();

    // Compare process: outputs vs model every cycle.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        check("cmd_ready", 32'(bus.cmd_ready), 32'(m_idle));
        check("res_valid", 32'(bus.res_valid), 32'(m_valid));
        check("res_data", 32'(bus.res_data), 32'(m_data));
        check("res_co", 32'(bus.res_co), 32'(m_co));
        check("res_co_any", 32'(bus.res_co_any), 32'(m_coany));
        check("rf_rdata", 32'(rf_rdata), 32'(m_rf[rf_raddr]));
        check("dp_a", 32'(dp_a),
              m_exec ? 32'(m_as[m_iter]) : 0);
        check("dp_b", 32'(dp_b), m_exec ? 32'(m_b) : 0);
        check("dp_opcode", 32'(dp_opcode),
              m_exec ? 32'(m_op) : 0);
        if (rst_n) model_step();
    end

    task automatic host_wr(input logic [1:0] ad,
                           input logic [15:0] d);
        wr_en   = 1;
        wr_addr = ad;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 0;
    endtask

    task automatic issue(input logic [2:0] op,
                         input logic [1:0] ra,
                         input logic [1:0] rb,
                         input logic sel,
                         input logic [15:0] imm,
                         input logic [1:0] rd,
                         input logic [3:0] rep);
        bus.cmd_op      = op;
        bus.cmd_ra      = ra;
        bus.cmd_rb      = rb;
        bus.cmd_imm_sel = sel;
        bus.cmd_imm     = imm;
        bus.cmd_rd      = rd;
        bus.cmd_rep     = rep;
        bus.cmd_valid   = 1;
        @(posedge clk);
        #1 bus.cmd_valid = 0;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!bus.res_valid && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
            check("busy_ready", 32'(bus.cmd_ready), 0);
        end
        if (!bus.res_valid) check("res_timeout", 0, 1);
    endtask

    task automatic release_res();
        bus.res_ready = 1;
        @(posedge clk);
        #1 bus.res_ready = 0;
        check("rel_ready", 32'(bus.cmd_ready), 1);
        check("rel_valid", 32'(bus.res_valid), 0);
    endtask

    task automatic rd_rf(input logic [1:0] ad,
                         input logic [15:0] exp,
                         input string nm);
        rf_raddr = ad;
        #1 check(nm, 32'(rf_rdata), 32'(exp));
    endtask

    int          cyc;
    logic [15:0] held;

    initial begin
        bus.cmd_valid   = 0;
        bus.cmd_op      = 0;
        bus.cmd_ra      = 0;
        bus.cmd_rb      = 0;
        bus.cmd_imm_sel = 0;
        bus.cmd_imm     = 0;
        bus.cmd_rd      = 0;
        bus.cmd_rep     = 0;
        bus.res_ready   = 0;
        #22 rst_n = 1;
        @(posedge clk);
        #1 check("rst_valid", 32'(bus.res_valid), 0);
        check("rst_data", 32'(bus.res_data), 0);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_dp_a", 32'(dp_a), 0);

        // 1: increment 5 four times
        host_wr(0, 16'd5);
        issue(OP_INC, 0, 0, 0, 0, 1, 4'd3);
        wait_res(cyc);
        check("t1_lat", cyc, 4);
        check("t1_data", 32'(bus.res_data), 9);
        check("t1_co", 32'(bus.res_co), 0);
        check("t1_any", 32'(bus.res_co_any), 0);
        release_res();
        rd_rf(1, 16'd9, "t1_rf1");

        // 2: wrap of 0xFFFF
        host_wr(0, 16'hFFFF);
        issue(OP_INC, 0, 0, 0, 0, 2, 4'd0);
        wait_res(cyc);
        check("t2a_lat", cyc, 1);
        check("t2a_data", 32'(bus.res_data), 0);
        check("t2a_co", 32'(bus.res_co), 1);
        check("t2a_any", 32'(bus.res_co_any), 1);
        release_res();
        issue(OP_INC, 0, 0, 0, 0, 2, 4'd1);
        wait_res(cyc);
        check("t2b_data", 32'(bus.res_data), 1);
        check("t2b_co", 32'(bus.res_co), 0);
        check("t2b_any", 32'(bus.res_co_any), 1);
        release_res();

        // 3: immediate subtract / add
        host_wr(0, 16'd100);
        issue(OP_SUB, 0, 3, 1, 16'd30, 3, 4'd0);
        wait_res(cyc);
        check("t3_sub", 32'(bus.res_data), 70);
        release_res();
        issue(OP_ADD, 0, 3, 1, 16'd30, 3, 4'd0);
        wait_res(cyc);
        check("t3_add", 32'(bus.res_data), 130);

        // 4: stall in DONE, stray cmd pulse ignored
        held = bus.res_data;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = (i == 2);
            @(posedge clk);
            #1 check("t4_valid", 32'(bus.res_valid), 1);
            check("t4_data", 32'(bus.res_data), 32'(held));
        end
        bus.cmd_valid = 0;
        release_res();

        // 5: write in accept cycle, then during EXEC
        host_wr(0, 16'd7);
        wr_en   = 1;
        wr_addr = 0;
        wr_data = 16'd50;
        issue(OP_PASS, 0, 0, 0, 0, 3, 4'd0);
        wr_en = 0;
        wait_res(cyc);
        check("t5_data", 32'(bus.res_data), 7);
        release_res();
        rd_rf(0, 16'd50, "t5_rf0");
        issue(OP_ADD, 1, 0, 1, 16'd1, 3, 4'd5);
        host_wr(2, 16'h1234);
        wait_res(cyc);
        check("t5b_data", 32'(bus.res_data), 15);
        release_res();
        rd_rf(2, 16'h0001, "t5_rf2");

        // 6: reset mid-EXEC with max-ish repeat
        issue(OP_INC, 0, 0, 0, 0, 1, 4'd10);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1 check("t6_valid", 32'(bus.res_valid), 0);
        check("t6_dp_a", 32'(dp_a), 0);
        check("t6_dp_op", 32'(dp_opcode), 0);
        for (int i = 0; i < 4; i++) begin
            rd_rf(2'(i), 16'd0, "t6_rf");
        end
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1 host_wr(0, 16'd3);
        issue(OP_ADD, 0, 0, 1, 16'd4, 1, 4'd2);
        wait_res(cyc);
        check("t6_data", 32'(bus.res_data), 15);
        release_res();

        // Max repeat: 16 iterations, counter must stop at 0
        issue(OP_DEC, 1, 0, 0, 0, 2, 4'd15);
        wait_res(cyc);
        check("max_lat", cyc, 16);
        check("max_data", 32'(bus.res_data), 32'hFFFF);
        check("max_any", 32'(bus.res_co_any), 1);
        check("max_co", 32'(bus.res_co), 0);
        release_res();
        repeat (3) @(posedge clk);
        #1 check("max_idle", 32'(bus.cmd_ready), 1);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
